// File: rtl/sram_table_ctrl_if.sv
// Host-side bundle for sram_table_ctrl: load stream, sweep control, SRAM write port, counter
// control and status.
interface sram_table_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              start_load;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              sweep_start;
  logic [ADDR_W-1:0] sweep_addr;
  logic [3:0]        sweep_delta;
  logic [7:0]        sweep_steps;
  logic              sweep_cont;
  logic              sweep_stop;

  logic                csb0;
  logic                web0;
  logic [DATA_W/8-1:0] wmask0;
  logic [ADDR_W-1:0]   addr0;
  logic [DATA_W-1:0]   din0;

  logic              preload;
  logic [ADDR_W-1:0] pl_data;
  logic              up_dn;
  logic [3:0]        delta;

  logic busy;
  logic load_done;
  logic sweep_done;
  logic err;

  modport master (
    output start_load, load_base, load_len, wr_valid, wr_data,
    output sweep_start, sweep_addr, sweep_delta, sweep_steps, sweep_cont, sweep_stop,
    input  wr_ready, csb0, web0, wmask0, addr0, din0,
    input  preload, pl_data, up_dn, delta, busy, load_done, sweep_done, err
  );

  modport slave (
    input  start_load, load_base, load_len, wr_valid, wr_data,
    input  sweep_start, sweep_addr, sweep_delta, sweep_steps, sweep_cont, sweep_stop,
    output wr_ready, csb0, web0, wmask0, addr0, din0,
    output preload, pl_data, up_dn, delta, busy, load_done, sweep_done, err
  );
endinterface

// File: rtl/sram_table_ctrl.sv
// Loads a host word stream into an SRAM table and drives an up/down phase-counter sweep.
// Every output is a flop whose next value is derived from the next state.
module sram_table_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  sram_table_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam int unsigned MaskW = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StLoad, StPreload, StUp, StDown} state_e;

  state_e state_q, state_d;

  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        steps_q, steps_d;
  logic [3:0]        dcfg_q, dcfg_d;
  logic              cont_q, cont_d;

  logic              wr_ready_q, wr_ready_d;
  logic              csb0_q, csb0_d;
  logic              web0_q, web0_d;
  logic [MaskW-1:0]  wmask0_q, wmask0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [DATA_W-1:0] din0_q, din0_d;
  logic              preload_q, preload_d;
  logic [ADDR_W-1:0] pl_data_q, pl_data_d;
  logic              up_dn_q, up_dn_d;
  logic [3:0]        delta_q, delta_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              sweep_done_q, sweep_done_d;
  logic              err_q, err_d;

  logic accept;
  logic wr_en;

  assign accept = (state_q == StLoad) && wr_ready_q && bus.wr_valid;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    steps_d      = steps_q;
    dcfg_d       = dcfg_q;
    cont_d       = cont_q;
    addr0_d      = addr0_q;
    din0_d       = din0_q;
    pl_data_d    = pl_data_q;
    wr_en        = 1'b0;
    err_d        = 1'b0;
    load_done_d  = 1'b0;
    sweep_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_load) begin
          // Load wins a simultaneous request; the losing sweep is flagged.
          err_d = bus.sweep_start;
          if ((bus.load_len == '0) || (bus.load_len > DepthW)) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
            rem_d   = bus.load_len;
            ptr_d   = bus.load_base;
          end
        end else if (bus.sweep_start) begin
          state_d   = StPreload;
          pl_data_d = bus.sweep_addr;
          dcfg_d    = bus.sweep_delta;
          steps_d   = bus.sweep_steps;
          cont_d    = bus.sweep_cont;
        end
      end
      StLoad: begin
        err_d = bus.start_load || bus.sweep_start;
        if (accept) begin
          wr_en   = 1'b1;
          addr0_d = ptr_q;
          din0_d  = bus.wr_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
          end
        end
      end
      StPreload: begin
        if (steps_q == 8'd0) begin
          state_d      = StIdle;
          sweep_done_d = 1'b1;
        end else begin
          state_d = StUp;
          cnt_d   = steps_q - 8'd1;
        end
      end
      StUp: begin
        if (cnt_q == 8'd0) begin
          state_d = StDown;
          cnt_d   = steps_q - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDown: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (cont_q) begin
          state_d = StUp;
          cnt_d   = steps_q - 8'd1;
        end else begin
          state_d      = StIdle;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StPreload) || (state_q == StUp) || (state_q == StDown)) begin
      err_d = bus.start_load || bus.sweep_start;
      // Abort overrides any leg completion, including a pending sweep_done.
      if (bus.sweep_stop) begin
        state_d      = StIdle;
        sweep_done_d = 1'b0;
      end
    end

    wr_ready_d = (state_d == StLoad);
    busy_d     = (state_d != StIdle);
    preload_d  = (state_d == StPreload);
    up_dn_d    = (state_d != StDown);
    delta_d    = ((state_d == StUp) || (state_d == StDown)) ? dcfg_q : 4'd0;
    csb0_d     = ~wr_en;
    web0_d     = ~wr_en;
    wmask0_d   = wr_en ? {MaskW{1'b1}} : {MaskW{1'b0}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      steps_q      <= '0;
      dcfg_q       <= '0;
      cont_q       <= 1'b0;
      wr_ready_q   <= 1'b0;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      wmask0_q     <= '0;
      addr0_q      <= '0;
      din0_q       <= '0;
      preload_q    <= 1'b0;
      pl_data_q    <= '0;
      up_dn_q      <= 1'b1;
      delta_q      <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      steps_q      <= steps_d;
      dcfg_q       <= dcfg_d;
      cont_q       <= cont_d;
      wr_ready_q   <= wr_ready_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      din0_q       <= din0_d;
      preload_q    <= preload_d;
      pl_data_q    <= pl_data_d;
      up_dn_q      <= up_dn_d;
      delta_q      <= delta_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      sweep_done_q <= sweep_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.csb0       = csb0_q;
  assign bus.web0       = web0_q;
  assign bus.wmask0     = wmask0_q;
  assign bus.addr0      = addr0_q;
  assign bus.din0       = din0_q;
  assign bus.preload    = preload_q;
  assign bus.pl_data    = pl_data_q;
  assign bus.up_dn      = up_dn_q;
  assign bus.delta      = delta_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.err        = err_q;

endmodule
